alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 32-bit ALU (ALUSel encodings 0-9: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Accepts operations from two independent requesters, for example the main datapath and an address/branch helper, over valid/ready handshakes.
- Grants one requester at a time, round-robin.
- Drives the ALU operand and select inputs from registered copies.
- Returns each registered result to the requester that issued it, over a valid/ready response channel.

Parameters:
SIGNAL_WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_sel  in  4  requester 0 ALUSel code
req0_a  in  SIGNAL_WIDTH  requester 0 operand A
req0_b  in  SIGNAL_WIDTH  requester 0 operand B
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  SIGNAL_WIDTH  result for requester 0
rsp0_err  out  1  requester 0 op code was illegal (10-15)
req1_valid, req1_ready, req1_sel, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data, rsp1_err: same as the requester 0 ports, for requester 1
ALUSel  out  4  to ALU select
alumux1_out  out  SIGNAL_WIDTH  to ALU operand A
alumux2_out  out  SIGNAL_WIDTH  to ALU operand B
alu_out  in  SIGNAL_WIDTH  from ALU result (combinational)
busy  out  1  high when state is not IDLE
last_grant  out  1  index of the most recently granted requester

Behaviour:
- Reset:
  - state=IDLE.
  - last_grant=1, so requester 0 wins first.
  - ALUSel=0, alumux1_out=0, alumux2_out=0.
  - All rsp*_valid=0, rsp*_data=0, rsp*_err=0.
  - All req*_ready=0.
  - busy=0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If no valid is high, remain in IDLE.
  - If exactly one valid is high, that requester is the winner.
  - If both valids are high, the winner is the requester != last_grant.
  - req<w>_ready=1 combinationally for the winner only. The other ready is 0.
  - On the accepting edge:
    - capture sel/a/b into ALUSel/alumux1_out/alumux2_out;
    - set last_grant<=w and owner<=w;
    - go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from registers.
  - Capture the result: if ALUSel<=9, result<=alu_out and err<=0; if ALUSel>=10, result<=0 and err<=1.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1, with rsp<owner>_data=result and rsp<owner>_err=err.
  - Data and err are held stable while the response is unacknowledged.
  - On rsp<owner>_valid & rsp<owner>_ready: go to IDLE and drop rsp<owner>_valid the next cycle.
  - The non-owner's rsp_ready is ignored. The non-owner's rsp_valid stays 0.
  - No req_ready is asserted while in EXEC or RESP.
- ALU drive outputs hold their last captured values outside EXEC and never change except at accept.
- rsp*_data holds its last value after the handshake.
- Latency:
  - Accept edge at T (end of cycle T).
  - rsp_valid high in cycle T+2.
  - With rsp_ready=1, the handshake completes at T+2, state is IDLE at T+3, and the next accept is possible at T+3.
  - Peak throughput is 1 op per 3 cycles.
- Requester rule: req valid/sel/a/b must be held until ready. The arbiter does not check this.
- Reset in EXEC or RESP:
  - the operation is discarded and no response is issued;
  - all outputs return to their reset values on the next cycle.
- Fairness:
  - With both requesters continuously valid, grants strictly alternate.
  - A lone requester may be granted back-to-back.
- busy=1 in EXEC and RESP.

Test Plan:
1. Reset, then req0 ADD (sel=0, a=5, b=7) alone with rsp0_ready=1 -> req0_ready at cycle 0, rsp0_valid at cycle 2, rsp0_data=12, rsp0_err=0, rsp1_valid stays 0.
2. Both requesters valid right after reset: req0 SUB (3,10) and req1 SRA (a=0x80000000, b=4) -> req0 granted first with rsp0_data=0xFFFFFFF9; req1 granted in the next IDLE with rsp1_data=0xF8000000; last_grant ends at 1.
3. Both requesters continuously valid for 6 ops -> grant order 0,1,0,1,0,1, with each op spaced 3 cycles.
4. Backpressure: rsp0_ready=0 for 5 cycles on an OR (0xF0, 0x0F) -> rsp0_valid stays high, rsp0_data stays 0xFF, no req_ready pulses, and busy=1 throughout; release -> IDLE the next cycle.
5. Illegal op sel=12 on req1 (a=1, b=1) -> rsp1_err=1, rsp1_data=0.
6. Assert rst during RESP with rsp0_ready=0 -> next cycle state is IDLE, all rsp_valid=0, ALU inputs=0, last_grant=1; the following req0 request is accepted normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between one ALU requester and the arbiter.
// The requester drives the operation and takes the result (master); the
// arbiter accepts the operation and returns the result (slave).
interface alu_arbiter_if #(
  parameter int SIGNAL_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [3:0]              sel;
  logic [SIGNAL_WIDTH-1:0] a;
  logic [SIGNAL_WIDTH-1:0] b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [SIGNAL_WIDTH-1:0] rsp_data;
  logic                    rsp_err;

  modport master (
    output valid, sel, a, b, rsp_ready,
    input  ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  valid, sel, a, b, rsp_ready,
    output ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared ALU.
// One operation is in flight at a time: IDLE accepts, EXEC lets the ALU
// settle on registered operands and captures its result, RESP hands the
// result back to whichever requester issued the operation.
module alu_arbiter #(
  parameter int SIGNAL_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_arbiter_if.slave            req0,
  alu_arbiter_if.slave            req1,
  output logic [3:0]              ALUSel,
  output logic [SIGNAL_WIDTH-1:0] alumux1_out,
  output logic [SIGNAL_WIDTH-1:0] alumux2_out,
  input  logic [SIGNAL_WIDTH-1:0] alu_out,
  output logic                    busy,
  output logic                    last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAST_LEGAL_SEL = 4'd9;

  state_t                  state;
  logic                    owner;
  logic                    winner;
  logic                    accept;
  logic                    owner_rsp_ready;
  logic [SIGNAL_WIDTH-1:0] exec_data;
  logic                    exec_err;

  // Pick the winner: a lone requester always wins, a tie goes to the
  // requester that was not granted last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = 1'b0;
    if (req0.valid && req1.valid) begin
      winner = ~last_grant;
    end else if (req1.valid) begin
      winner = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0.valid || req1.valid) && !rst;
  assign req0.ready = accept && !winner;
  assign req1.ready = accept &&  winner;
  assign busy       = (state != IDLE);

  // Result to capture at the end of EXEC: illegal selects return zero with
  // the error flag instead of whatever the ALU happens to produce.
  always_comb begin
    exec_data = alu_out;
    exec_err  = 1'b0;
    if (ALUSel > LAST_LEGAL_SEL) begin
      exec_data = '0;
      exec_err  = 1'b1;
    end
  end

  assign owner_rsp_ready = owner ? req1.rsp_ready : req0.rsp_ready;

  // Sequencer: accept, execute, respond. Reset discards any in-flight op.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples its inputs from before the clock edge.
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      ALUSel         <= '0;
      alumux1_out    <= '0;
      alumux2_out    <= '0;
      req0.rsp_valid <= 1'b0;
      req0.rsp_data  <= '0;
      req0.rsp_err   <= 1'b0;
      req1.rsp_valid <= 1'b0;
      req1.rsp_data  <= '0;
      req1.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ALUSel      <= winner ? req1.sel : req0.sel;
            alumux1_out <= winner ? req1.a   : req0.a;
            alumux2_out <= winner ? req1.b   : req0.b;
            last_grant  <= winner;
            owner       <= winner;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            req1.rsp_valid <= 1'b1;
            req1.rsp_data  <= exec_data;
            req1.rsp_err   <= exec_err;
          end else begin
            req0.rsp_valid <= 1'b1;
            req0.rsp_data  <= exec_data;
            req0.rsp_err   <= exec_err;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            if (owner) begin
              req1.rsp_valid <= 1'b0;
            end else begin
              req0.rsp_valid <= 1'b0;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop and
// every expected result is a hand-computed constant.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ALUSel;
  logic [31:0] alumux1_out;
  logic [31:0] alumux2_out;
  logic [31:0] alu_out;
  logic        busy;
  logic        last_grant;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  alu_arbiter_if #(.SIGNAL_WIDTH(32)) req0_if ();
  alu_arbiter_if #(.SIGNAL_WIDTH(32)) req1_if ();

  alu_arbiter #(.SIGNAL_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0_if),
    .req1        (req1_if),
    .ALUSel      (ALUSel),
    .alumux1_out (alumux1_out),
    .alumux2_out (alumux2_out),
    .alu_out     (alu_out),
    .busy        (busy),
    .last_grant  (last_grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; illegal selects return a marker value so zeroing shows.
  always_comb begin
    case (ALUSel)
      4'd0:    alu_out = alumux1_out + alumux2_out;
      4'd1:    alu_out = alumux1_out - alumux2_out;
      4'd2:    alu_out = alumux1_out << alumux2_out[4:0];
      4'd3:    alu_out = {31'b0, $signed(alumux1_out) < $signed(alumux2_out)};
      4'd4:    alu_out = {31'b0, alumux1_out < alumux2_out};
      4'd5:    alu_out = alumux1_out ^ alumux2_out;
      4'd6:    alu_out = alumux1_out >> alumux2_out[4:0];
      4'd7:    alu_out = $signed(alumux1_out) >>> alumux2_out[4:0];
      4'd8:    alu_out = alumux1_out | alumux2_out;
      4'd9:    alu_out = alumux1_out & alumux2_out;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic v, input logic [3:0] sel,
                           input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req0_if.valid = v; req0_if.sel = sel; req0_if.a = a; req0_if.b = b;
    end else begin
      req1_if.valid = v; req1_if.sel = sel; req1_if.a = a; req1_if.b = b;
    end
  endtask

  // Entered one unit after an edge; returns one unit after the accept edge.
  task automatic wait_accept(output int who, output int at);
    bit done = 0;
    who = -1;
    at  = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (req0_if.ready || req1_if.ready) begin
        who  = req1_if.ready ? 1 : 0;
        at   = cyc;
        done = 1;
        check("single_ready", {31'b0, req0_if.ready & req1_if.ready}, 32'd0);
      end
      tick();
    end
    if (!done) check("accept_timeout", 32'd1, 32'd0);
  endtask

  // Waits for the response of requester 'who' and checks it; the caller has
  // already raised that requester's rsp_ready.
  task automatic wait_rsp(input int who, input logic [31:0] exp_data,
                          input logic exp_err, input int acc_cyc, input string tag);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((who == 0) ? req0_if.rsp_valid : req1_if.rsp_valid) begin
        done = 1;
        check({tag, "_data"}, (who == 0) ? req0_if.rsp_data : req1_if.rsp_data, exp_data);
        check({tag, "_err"}, {31'b0, (who == 0) ? req0_if.rsp_err : req1_if.rsp_err},
              {31'b0, exp_err});
        check({tag, "_other_valid"},
              {31'b0, (who == 0) ? req1_if.rsp_valid : req0_if.rsp_valid}, 32'd0);
        check({tag, "_latency"}, cyc - acc_cyc, 32'd2);
      end
      tick();
    end
    if (!done) check({tag, "_rsp_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int who;
    int acc;
    int prev_acc;

    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    req0_if.rsp_ready = 1'b1;
    req1_if.rsp_ready = 1'b1;

    // Reset state, with a request pending to show ready stays low in reset.
    rst = 1'b1;
    tick();
    drive_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    tick();
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_last_grant", {31'b0, last_grant}, 32'd1);
    check("rst_alusel", {28'b0, ALUSel}, 32'd0);
    check("rst_mux1", alumux1_out, 32'd0);
    check("rst_mux2", alumux2_out, 32'd0);
    check("rst_ready0", {31'b0, req0_if.ready}, 32'd0);
    check("rst_ready1", {31'b0, req1_if.ready}, 32'd0);
    check("rst_rsp0_valid", {31'b0, req0_if.rsp_valid}, 32'd0);
    check("rst_rsp1_valid", {31'b0, req1_if.rsp_valid}, 32'd0);
    check("rst_rsp0_data", req0_if.rsp_data, 32'd0);
    check("rst_rsp1_err", {31'b0, req1_if.rsp_err}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: lone ADD on requester 0.
    wait_accept(who, acc);
    check("t1_winner", who, 32'd0);
    check("t1_exec_busy", {31'b0, busy}, 32'd1);
    check("t1_exec_sel", {28'b0, ALUSel}, 32'd0);
    check("t1_exec_a", alumux1_out, 32'd5);
    check("t1_exec_b", alumux2_out, 32'd7);
    check("t1_exec_ready0", {31'b0, req0_if.ready}, 32'd0);
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    wait_rsp(0, 32'd12, 1'b0, acc, "t1");
    #1;
    check("t1_idle_busy", {31'b0, busy}, 32'd0);
    check("t1_rsp0_dropped", {31'b0, req0_if.rsp_valid}, 32'd0);
    check("t1_rsp0_hold", req0_if.rsp_data, 32'd12);
    check("t1_mux_hold", alumux1_out, 32'd5);

    // 2: both valid straight after reset, requester 0 wins first.
    do_reset();
    drive_req(0, 1'b1, 4'd1, 32'd3, 32'd10);
    drive_req(1, 1'b1, 4'd7, 32'h8000_0000, 32'd4);
    wait_accept(who, acc);
    check("t2_first", who, 32'd0);
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    wait_rsp(0, 32'hFFFF_FFF9, 1'b0, acc, "t2_sub");
    wait_accept(who, acc);
    check("t2_second", who, 32'd1);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    wait_rsp(1, 32'hF800_0000, 1'b0, acc, "t2_sra");
    #1;
    check("t2_last_grant", {31'b0, last_grant}, 32'd1);

    // 3: both continuously valid, grants alternate every 3 cycles.
    drive_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
    drive_req(1, 1'b1, 4'd5, 32'hFF, 32'h0F);
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      wait_accept(who, acc);
      check($sformatf("t3_grant%0d", i), who, i % 2);
      if (i > 0) check($sformatf("t3_spacing%0d", i), acc - prev_acc, 32'd3);
      prev_acc = acc;
      if (who == 0) wait_rsp(0, 32'd3, 1'b0, acc, "t3_add");
      else          wait_rsp(1, 32'hF0, 1'b0, acc, "t3_xor");
    end
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    // 4: backpressure on an OR while requester 1 waits with an illegal op.
    req0_if.rsp_ready = 1'b0;
    drive_req(0, 1'b1, 4'd8, 32'hF0, 32'h0F);
    wait_accept(who, acc);
    check("t4_winner", who, 32'd0);
    check("t4_last_grant", {31'b0, last_grant}, 32'd0);
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b1, 4'd12, 32'd1, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t4_valid%0d", i), {31'b0, req0_if.rsp_valid}, 32'd1);
      check($sformatf("t4_data%0d", i), req0_if.rsp_data, 32'hFF);
      check($sformatf("t4_busy%0d", i), {31'b0, busy}, 32'd1);
      check($sformatf("t4_noready%0d", i),
            {31'b0, req0_if.ready | req1_if.ready}, 32'd0);
      tick();
    end
    req0_if.rsp_ready = 1'b1;
    tick();
    check("t4_release_idle", {31'b0, busy}, 32'd0);
    check("t4_release_valid", {31'b0, req0_if.rsp_valid}, 32'd0);
    check("t4_release_hold", req0_if.rsp_data, 32'hFF);

    // 5: illegal select on requester 1.
    wait_accept(who, acc);
    check("t5_winner", who, 32'd1);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    wait_rsp(1, 32'd0, 1'b1, acc, "t5_illegal");

    // 6: reset while a response is stalled, then a normal op.
    req0_if.rsp_ready = 1'b0;
    drive_req(0, 1'b1, 4'd9, 32'hF0F0, 32'hFF00);
    wait_accept(who, acc);
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    #1;
    check("t6_pre_valid", {31'b0, req0_if.rsp_valid}, 32'd1);
    check("t6_pre_data", req0_if.rsp_data, 32'hF000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_rsp0_valid", {31'b0, req0_if.rsp_valid}, 32'd0);
    check("t6_rsp1_valid", {31'b0, req1_if.rsp_valid}, 32'd0);
    check("t6_rsp0_data", req0_if.rsp_data, 32'd0);
    check("t6_mux1", alumux1_out, 32'd0);
    check("t6_mux2", alumux2_out, 32'd0);
    check("t6_sel", {28'b0, ALUSel}, 32'd0);
    check("t6_last_grant", {31'b0, last_grant}, 32'd1);
    req0_if.rsp_ready = 1'b1;
    drive_req(0, 1'b1, 4'd0, 32'd100, 32'd23);
    wait_accept(who, acc);
    check("t6_winner", who, 32'd0);
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    wait_rsp(0, 32'd123, 1'b0, acc, "t6_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
